// File: rtl/id_ex_stage_register_if.sv
// ID/EX stage bus: decode/hazard-side inputs and execute-side registered outputs.
// The master modport is the pipeline driver; the slave modport is the stage register.
interface id_ex_stage_register_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH     = 10
);
    logic                      Enable;
    logic                      DisableControlSignals;
    logic                      Flush;
    logic                      ID_Valid;
    logic [CTRL_WIDTH-1:0]     ID_Control;
    logic [DATA_WIDTH-1:0]     ID_ReadData1;
    logic [DATA_WIDTH-1:0]     ID_ReadData2;
    logic [DATA_WIDTH-1:0]     ID_SignExtImm;
    logic [DATA_WIDTH-1:0]     ID_PC_4;
    logic [REG_ADDR_WIDTH-1:0] ID_Rs;
    logic [REG_ADDR_WIDTH-1:0] ID_Rt;
    logic [REG_ADDR_WIDTH-1:0] ID_Rd;

    logic                      EX_Valid;
    logic [CTRL_WIDTH-1:0]     EX_Control;
    logic [DATA_WIDTH-1:0]     EX_ReadData1;
    logic [DATA_WIDTH-1:0]     EX_ReadData2;
    logic [DATA_WIDTH-1:0]     EX_SignExtImm;
    logic [DATA_WIDTH-1:0]     EX_PC_4;
    logic [REG_ADDR_WIDTH-1:0] EX_Rs;
    logic [REG_ADDR_WIDTH-1:0] EX_Rt;
    logic [REG_ADDR_WIDTH-1:0] EX_Rd;
    logic                      ID_EX_MemRead;
    logic [REG_ADDR_WIDTH-1:0] ID_EX_WriteRegister;

    modport master (
        output Enable, DisableControlSignals, Flush, ID_Valid, ID_Control,
               ID_ReadData1, ID_ReadData2, ID_SignExtImm, ID_PC_4, ID_Rs, ID_Rt, ID_Rd,
        input  EX_Valid, EX_Control, EX_ReadData1, EX_ReadData2, EX_SignExtImm, EX_PC_4,
               EX_Rs, EX_Rt, EX_Rd, ID_EX_MemRead, ID_EX_WriteRegister
    );

    modport slave (
        input  Enable, DisableControlSignals, Flush, ID_Valid, ID_Control,
               ID_ReadData1, ID_ReadData2, ID_SignExtImm, ID_PC_4, ID_Rs, ID_Rt, ID_Rd,
        output EX_Valid, EX_Control, EX_ReadData1, EX_ReadData2, EX_SignExtImm, EX_PC_4,
               EX_Rs, EX_Rt, EX_Rd, ID_EX_MemRead, ID_EX_WriteRegister
    );
endinterface

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register with flush, hold and hazard-unit bubble insertion.
// Optional STALL_STATS_EN adds saturating BubbleCount/FlushCount outputs.
module id_ex_stage_register #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH     = 10,
    parameter int MEMREAD_BIT    = 3,
    parameter int REGDST_BIT     = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    id_ex_stage_register_if.slave  bus
`ifdef STALL_STATS_EN
    ,
    output logic [15:0]            BubbleCount,
    output logic [15:0]            FlushCount
`endif
);
    logic                      valid_q, valid_d;
    logic [CTRL_WIDTH-1:0]     ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0]     rd1_q, rd1_d;
    logic [DATA_WIDTH-1:0]     rd2_q, rd2_d;
    logic [DATA_WIDTH-1:0]     imm_q, imm_d;
    logic [DATA_WIDTH-1:0]     pc4_q, pc4_d;
    logic [REG_ADDR_WIDTH-1:0] rs_q, rs_d;
    logic [REG_ADDR_WIDTH-1:0] rt_q, rt_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [REG_ADDR_WIDTH-1:0] wreg_q, wreg_d;

    logic flush_path;
    logic bubble_path;
    logic load_path;

    assign flush_path  = bus.Flush;
    assign bubble_path = !bus.Flush && bus.Enable && !bus.DisableControlSignals;
    assign load_path   = !bus.Flush && bus.Enable && bus.DisableControlSignals;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        pc4_d   = pc4_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        wreg_d  = wreg_q;

        // Flush, bubble and load all capture the datapath; only hold keeps it.
        if (flush_path || bubble_path || load_path) begin
            rd1_d   = bus.ID_ReadData1;
            rd2_d   = bus.ID_ReadData2;
            imm_d   = bus.ID_SignExtImm;
            pc4_d   = bus.ID_PC_4;
            rs_d    = bus.ID_Rs;
            rt_d    = bus.ID_Rt;
            rd_d    = bus.ID_Rd;
            valid_d = 1'b0;
            ctrl_d  = '0;
            wreg_d  = '0;
        end

        // An invalid decode slot is treated exactly like a bubble.
        if (load_path && bus.ID_Valid) begin
            valid_d = 1'b1;
            ctrl_d  = bus.ID_Control;
            wreg_d  = bus.ID_Control[REGDST_BIT] ? bus.ID_Rd : bus.ID_Rt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            pc4_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            wreg_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            pc4_q   <= pc4_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            wreg_q  <= wreg_d;
        end
    end

    assign bus.EX_Valid            = valid_q;
    assign bus.EX_Control          = ctrl_q;
    assign bus.EX_ReadData1        = rd1_q;
    assign bus.EX_ReadData2        = rd2_q;
    assign bus.EX_SignExtImm       = imm_q;
    assign bus.EX_PC_4             = pc4_q;
    assign bus.EX_Rs               = rs_q;
    assign bus.EX_Rt               = rt_q;
    assign bus.EX_Rd               = rd_q;
    assign bus.ID_EX_MemRead       = ctrl_q[MEMREAD_BIT];
    assign bus.ID_EX_WriteRegister = wreg_q;

`ifdef STALL_STATS_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (bubble_path && (bubble_cnt_q != 16'hFFFF))
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        if (flush_path && (flush_cnt_q != 16'hFFFF))
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign BubbleCount = bubble_cnt_q;
    assign FlushCount  = flush_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_stage_register.sv
// Randomized and directed bench for id_ex_stage_register against a behavioural EX-slot model.
// Counter checks are compiled in when STALL_STATS_EN is defined.
module tb_id_ex_stage_register;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 10;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    id_ex_stage_register_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CTRL_WIDTH(CW)) bus ();

`ifdef STALL_STATS_EN
    logic [15:0] bubble_count;
    logic [15:0] flush_count;
`endif

    id_ex_stage_register #(
        .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CTRL_WIDTH(CW), .MEMREAD_BIT(3), .REGDST_BIT(0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef STALL_STATS_EN
        ,
        .BubbleCount (bubble_count),
        .FlushCount  (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the instruction sitting in EX, as a record of what EX should show.
    typedef struct {
        logic          valid;
        logic [CW-1:0] ctrl;
        logic [DW-1:0] rd1, rd2, imm, pc4;
        logic [AW-1:0] rs, rt, rd, wreg;
    } ex_slot_t;

    ex_slot_t    m;
    int unsigned m_bubbles;
    int unsigned m_flushes;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m = '{valid: 1'b0, ctrl: '0, rd1: '0, rd2: '0, imm: '0, pc4: '0,
              rs: '0, rt: '0, rd: '0, wreg: '0};
        m_bubbles = 0;
        m_flushes = 0;
    endtask

    // One rising edge: decide what instruction EX receives from the current ID inputs.
    task automatic model_edge();
        bit takes_new;
        bit real_instr;
        takes_new  = bus.Flush || bus.Enable;
        real_instr = !bus.Flush && bus.DisableControlSignals && bus.ID_Valid;
        if (bus.Flush) m_flushes++;
        else if (bus.Enable && !bus.DisableControlSignals) m_bubbles++;
        if (takes_new) begin
            m.rd1 = bus.ID_ReadData1; m.rd2 = bus.ID_ReadData2;
            m.imm = bus.ID_SignExtImm; m.pc4 = bus.ID_PC_4;
            m.rs = bus.ID_Rs; m.rt = bus.ID_Rt; m.rd = bus.ID_Rd;
            m.valid = real_instr;
            m.ctrl  = real_instr ? bus.ID_Control : '0;
            if (!real_instr)            m.wreg = '0;
            else if (bus.ID_Control[0]) m.wreg = bus.ID_Rd;
            else                        m.wreg = bus.ID_Rt;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 32'(bus.EX_Valid), 32'(m.valid));
        check({tag, ".ctrl"},  32'(bus.EX_Control), 32'(m.ctrl));
        check({tag, ".rd1"},   bus.EX_ReadData1, m.rd1);
        check({tag, ".rd2"},   bus.EX_ReadData2, m.rd2);
        check({tag, ".imm"},   bus.EX_SignExtImm, m.imm);
        check({tag, ".pc4"},   bus.EX_PC_4, m.pc4);
        check({tag, ".rs"},    32'(bus.EX_Rs), 32'(m.rs));
        check({tag, ".rt"},    32'(bus.EX_Rt), 32'(m.rt));
        check({tag, ".rd"},    32'(bus.EX_Rd), 32'(m.rd));
        check({tag, ".memrd"}, 32'(bus.ID_EX_MemRead), 32'(m.ctrl[3]));
        check({tag, ".wreg"},  32'(bus.ID_EX_WriteRegister), 32'(m.wreg));
`ifdef STALL_STATS_EN
        check({tag, ".bcnt"},  32'(bubble_count), (m_bubbles > 65535) ? 32'hFFFF : m_bubbles);
        check({tag, ".fcnt"},  32'(flush_count), (m_flushes > 65535) ? 32'hFFFF : m_flushes);
`endif
    endtask

    task automatic drive(input bit en, input bit dcs, input bit fl, input bit vld,
                         input logic [CW-1:0] ctrl, input logic [AW-1:0] rt, input logic [AW-1:0] rd);
        bus.Enable = en; bus.DisableControlSignals = dcs; bus.Flush = fl; bus.ID_Valid = vld;
        bus.ID_Control = ctrl; bus.ID_Rt = rt; bus.ID_Rd = rd;
        bus.ID_Rs = AW'($urandom);
        bus.ID_ReadData1 = $urandom; bus.ID_ReadData2 = $urandom;
        bus.ID_SignExtImm = $urandom; bus.ID_PC_4 = $urandom;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        if (reset) model_edge();
        #1;
        check_outputs(tag);
        $display("[TB] %s en=%0b dcs=%0b fl=%0b vld=%0b ctrl=%03h -> ex_valid=%0b wreg=%0d",
                 tag, bus.Enable, bus.DisableControlSignals, bus.Flush, bus.ID_Valid,
                 bus.ID_Control, bus.EX_Valid, bus.ID_EX_WriteRegister);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b0;
        model_clear();
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, '0);
        do_reset();
        #1 check_outputs("reset_state");

        // Normal load: RegDst=1, MemRead=1 selects Rd.
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 1'b1, 10'h009, 5'd5, 5'd7);
        step("load_rd");
        check("load_rd.wreg7", 32'(bus.ID_EX_WriteRegister), 32'd7);

        // Asynchronous reset in mid-cycle while EX holds a real instruction.
        @(posedge clk); model_edge();
        #2 reset = 1'b0;
        model_clear();
        #1 check_outputs("async_reset");
        @(posedge clk); #1 check_outputs("reset_held");
        @(negedge clk); reset = 1'b1;

        // Load-use: lw with Rt=8, then one bubble edge, then the dependent instruction.
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 1'b1, 10'h008, 5'd8, 5'd3);
        step("lw_load");
        check("lw_load.wreg8", 32'(bus.ID_EX_WriteRegister), 32'd8);
        @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b1, 10'h3F1, 5'd9, 5'd8);
        step("bubble");
        check("bubble.wreg0", 32'(bus.ID_EX_WriteRegister), 32'd0);
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 1'b1, 10'h3F1, 5'd9, 5'd8);
        step("dependent");

        // Flush beats both hold and bubble.
        @(negedge clk); drive(1'b0, 1'b0, 1'b1, 1'b1, 10'h2FF, 5'd4, 5'd6);
        step("flush_prio");
        check("flush_prio.valid0", 32'(bus.EX_Valid), 32'd0);

        // Hold for three edges with changing inputs, then release.
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 1'b1, 10'h00D, 5'd11, 5'd12);
        step("pre_hold");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(1'b0, 1'b1, 1'b0, 1'b1, CW'($urandom), AW'($urandom), AW'($urandom));
            step($sformatf("hold%0d", i));
        end
        @(negedge clk); drive(1'b1, 1'b1, 1'b0, 1'b1, 10'h050, 5'd13, 5'd14);
        step("release");

        // Randomized traffic with biased control inputs.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            drive($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0, $urandom_range(7, 0) == 0,
                  $urandom_range(7, 0) != 0, CW'($urandom), AW'($urandom), AW'($urandom));
            step($sformatf("rand%0d", i));
        end

`ifdef STALL_STATS_EN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b1, CW'($urandom), AW'($urandom), AW'($urandom));
            step($sformatf("cnt_bubble%0d", i));
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive(1'b0, 1'b1, 1'b1, 1'b1, CW'($urandom), AW'($urandom), AW'($urandom));
            step($sformatf("cnt_flush%0d", i));
        end
        check("cnt.bubble3", 32'(bubble_count), 32'd3);
        check("cnt.flush2", 32'(flush_count), 32'd2);

        // Drive the bubble counter to saturation, then one more bubble.
        do_reset();
        @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b1, 10'h001, 5'd1, 5'd2);
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk); model_edge();
        end
        #1 check("sat.preload", 32'(bubble_count), 32'hFFFF);
        @(negedge clk);
        step("sat.bubble");
        check("sat.stays", 32'(bubble_count), 32'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
